// File: rtl/lockstep_run_ctrl.sv
// Run sequencer for the dual-copy LB non-interference harness: owns the shared core
// reset, steps RESET/INIT/RUN/CHECK and keeps a sticky divergence verdict.
module lockstep_run_ctrl #(
   parameter int unsigned RESET_CYCLES = 2,
   parameter int unsigned INIT_CYCLES  = 8,
   parameter int unsigned CHECK_CYCLE  = 14
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        abort,
   input  logic        lb_valid1,
   input  logic        lb_valid2,
   input  logic [31:0] lb_addr1,
   input  logic [31:0] lb_addr2,
   input  logic [31:0] lb_data1,
   input  logic [31:0] lb_data2,
   output logic        core_reset,
   output logic        init_phase,
   output logic        running,
   output logic        check_strobe,
   output logic [7:0]  cycle_cnt,
   output logic        diverge_flag,
   output logic [7:0]  diverge_cycle,
   output logic        done,
   output logic        pass
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET,
      S_INIT,
      S_RUN,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic [7:0] RESET_LAST = 8'(RESET_CYCLES - 1);
   localparam logic [7:0] INIT_LAST  = 8'(INIT_CYCLES - 1);
   localparam logic [7:0] RUN_LAST   = 8'(CHECK_CYCLE - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       core_reset_q, core_reset_d;
   logic       flag_q, flag_d;
   logic [7:0] dcyc_q, dcyc_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;

   logic       diverge;
   logic       cmp_en;
   logic       is_running;

   // Entries that are invalid in both copies are don't-care, whatever their payload.
   assign diverge = (lb_valid1 ^ lb_valid2)
                  | (lb_valid1 & lb_valid2 & ((lb_addr1 != lb_addr2) | (lb_data1 != lb_data2)));

   assign cmp_en     = (state_q == S_INIT) || (state_q == S_RUN) || (state_q == S_CHECK);
   assign is_running = cmp_en || (state_q == S_RESET);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      flag_d       = flag_q;
      dcyc_d       = dcyc_q;
      done_d       = done_q;
      pass_d       = pass_q;
      core_reset_d = 1'b1;

      if (is_running) begin
         cnt_d = cnt_q + 8'd1;
      end

      if (cmp_en && diverge && !flag_q) begin
         flag_d = 1'b1;
         dcyc_d = cnt_q;
      end

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RESET;
               cnt_d   = 8'd0;
               flag_d  = 1'b0;
               dcyc_d  = 8'd0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end
         S_RESET: if (cnt_q == RESET_LAST) state_d = S_INIT;
         S_INIT:  if (cnt_q == INIT_LAST)  state_d = S_RUN;
         S_RUN:   if (cnt_q == RUN_LAST)   state_d = S_CHECK;
         S_CHECK: begin
            // The CHECK cycle's own comparison still counts toward the verdict.
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = !(flag_q || diverge);
         end
         default: state_d = S_IDLE;
      endcase

      if (is_running && abort) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
         pass_d  = 1'b0;
      end

      core_reset_d = (state_d == S_IDLE) || (state_d == S_RESET) || (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= 8'd0;
         core_reset_q <= 1'b1;
         flag_q       <= 1'b0;
         dcyc_q       <= 8'd0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         core_reset_q <= core_reset_d;
         flag_q       <= flag_d;
         dcyc_q       <= dcyc_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
      end
   end

   assign core_reset    = core_reset_q;
   assign init_phase    = (state_q == S_INIT);
   assign running       = is_running;
   assign check_strobe  = (state_q == S_CHECK);
   assign cycle_cnt     = cnt_q;
   assign diverge_flag  = flag_q;
   assign diverge_cycle = dcyc_q;
   assign done          = done_q;
   assign pass          = pass_q;

endmodule

// File: doc/lockstep_run_ctrl.md
# lockstep_run_ctrl

Run sequencer for the dual-copy Sodor5 load-buffer (LB) non-interference harness. It owns the shared core reset. It steps the two core copies through a fixed schedule: reset hold, init window, run window, then a single check cycle. Every cycle after reset release it compares the two copies' LB table ports and keeps a sticky divergence verdict with the cycle of first divergence. It replaces the ad-hoc counter/reset/assert logic in the harness, so the harness can instantiate one controller and read `pass`/`diverge_flag`.

## Interface
Parameters:
- `RESET_CYCLES`, default 2: cycles `core_reset` is held high after `start` is accepted.
- `INIT_CYCLES`, default 8: cycle index at which the init window ends.
- `CHECK_CYCLE`, default 14: cycle index at which the verdict is sampled.
- Legal range: 1 ≤ `RESET_CYCLES` < `INIT_CYCLES` < `CHECK_CYCLE` ≤ 255.

Ports:
- `clk` in 1: single clock, all state on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a run; sampled only in IDLE or DONE.
- `abort` in 1: cancel the run in progress.
- `lb_valid1`, `lb_valid2` in 1 each: LB table valid bit from copy 1 and copy 2.
- `lb_addr1`, `lb_addr2` in 32 each: LB table address from copy 1 and copy 2.
- `lb_data1`, `lb_data2` in 32 each: LB table data from copy 1 and copy 2.
- `core_reset` out 1: active-high reset driven to both core copies.
- `init_phase` out 1: high in INIT.
- `running` out 1: high in RESET, INIT, RUN and CHECK.
- `check_strobe` out 1: high for the single CHECK cycle.
- `cycle_cnt` out 8: cycles since `start` was accepted.
- `diverge_flag` out 1: sticky divergence seen.
- `diverge_cycle` out 8: `cycle_cnt` value at the first divergence.
- `done` out 1: run complete.
- `pass` out 1: `done` and no divergence.

## Operation
- Divergence term, combinational: `lb_valid1 ^ lb_valid2`, OR (both valid AND `lb_addr` differs), OR (both valid AND `lb_data` differs). Invalid-but-equal entries never diverge.
- States:
  - IDLE: `core_reset`=1.
  - RESET: `core_reset`=1.
  - INIT: `core_reset`=0, `init_phase`=1.
  - RUN: `core_reset`=0.
  - CHECK: `core_reset`=0, `check_strobe`=1.
  - DONE: `core_reset`=1, `done`=1.
- Transitions:
  - IDLE/DONE with `start` → RESET. `cycle_cnt`, `diverge_flag`, `diverge_cycle`, `done` and `pass` clear to 0.
  - RESET → INIT when `cycle_cnt` == `RESET_CYCLES`-1.
  - INIT → RUN when `cycle_cnt` == `INIT_CYCLES`-1.
  - RUN → CHECK when `cycle_cnt` == `CHECK_CYCLE`-1.
  - CHECK → DONE unconditionally.
  - Any running state with `abort` → IDLE. `done` and `pass` stay 0; `diverge_flag` and `diverge_cycle` keep their values until the next `start`.
- `cycle_cnt` increments by 1 every running cycle and is 0 in the first RESET cycle. It freezes in DONE and IDLE. It never wraps, because `CHECK_CYCLE` ≤ 255.
- Comparison is enabled in INIT, RUN and CHECK, i.e. whenever `core_reset`=0. RESET is excluded because core state is undefined there.
- On the first enabled cycle with the divergence term true, `diverge_flag` is set and `diverge_cycle` loads `cycle_cnt`. Later divergences do not update `diverge_cycle`.
- The CHECK-cycle comparison counts toward the verdict. `pass` is registered at the CHECK→DONE edge as NOT(`diverge_flag` OR divergence in the CHECK cycle).
- Simultaneous events:
  - `abort` wins over the state advance.
  - `start` is ignored while running.
  - `start` in DONE restarts immediately.

## Timing
- Reset values: state IDLE, `core_reset`=1; all other outputs 0.
- `reset_n` low mid-run forces IDLE asynchronously and clears all flags.
- All outputs are registered, except that `init_phase`, `running` and `check_strobe` are decoded directly from the state register.
- With default parameters, `start` accepted at edge E:
  - `core_reset` is high for edges E..E+1 and low from cycle 2.
  - INIT covers `cycle_cnt` 2..7.
  - RUN covers `cycle_cnt` 8..13.
  - CHECK occurs at `cycle_cnt` 14.
  - `done` and `pass` are valid at `cycle_cnt` 15, i.e. 16 cycles after `start`.
- Divergence capture latency: `diverge_flag` rises one cycle after the divergent inputs.

## Test plan
- Identical copies, both `lb_valid`=0 throughout, default parameters, `start` pulse → `core_reset` is low for exactly 13 cycles; `check_strobe` pulses once at `cycle_cnt`=14; `done`=1 and `pass`=1 at `cycle_cnt`=15.
- Both valid, `lb_addr1`=0x64, `lb_addr2`=0x68 at `cycle_cnt`=9 only → `diverge_flag`=1 from cycle 10; `diverge_cycle`=9; `pass`=0.
- `lb_valid1`=1 and `lb_valid2`=0 at `cycle_cnt`=1 (RESET) → ignored; `pass`=1. The same mismatch at `cycle_cnt`=14 (CHECK) → `pass`=0, `diverge_cycle`=14.
- Divergences on data at cycles 5 and 11 → `diverge_cycle`=5, `diverge_flag` stays 1.
- `abort` at `cycle_cnt`=6 → IDLE next cycle, `core_reset`=1, `done`=0. A following `start` → counter restarts at 0 and flags are cleared.
- `reset_n` pulsed low at `cycle_cnt`=10 → immediately `core_reset`=1, all flags 0, state IDLE. `start` during RUN → no effect.
